// File: rtl/mpc_mul_pkg.sv
// Shared widths and operand/product types for the MPC multiplier path.
package mpc_mul_pkg;

    localparam int MUL_A_W = 21;
    localparam int MUL_B_W = 15;
    localparam int MUL_P_W = 36;

    typedef logic signed [MUL_A_W-1:0] mul_a_t;
    typedef logic        [MUL_B_W-1:0] mul_b_t;
    typedef logic signed [MUL_P_W-1:0] mul_p_t;

endpackage

// File: rtl/mpc_mul_mul_21s_15ns_36_4_1.sv
// Pipelined signed 21 x unsigned 15 -> signed 36 multiplier.
// Product formed at the input, then NUM_STAGE clock-enabled registers.
module mpc_mul_mul_21s_15ns_36_4_1
    import mpc_mul_pkg::*;
#(
    parameter int NUM_STAGE = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   ce,
    input  mul_a_t din0,
    input  mul_b_t din1,
    output mul_p_t dout
);

    logic signed [MUL_P_W-1:0] ax;
    logic signed [MUL_P_W-1:0] bx;
    mul_p_t                    prod;
    mul_p_t                    pipe [NUM_STAGE];

    // Full range fits in 36 bits, so the truncated product is exact.
    always_comb begin
        ax   = MUL_P_W'(din0);
        bx   = $signed({{(MUL_P_W-MUL_B_W){1'b0}}, din1});
        prod = ax * bx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                pipe[i] <= '0;
            end
        end else if (ce) begin
            pipe[0] <= prod;
            for (int i = 1; i < NUM_STAGE; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[NUM_STAGE-1];

endmodule

// File: rtl/mpc_rr_pick.sv
// Combinational round-robin pick: lowest requester at or after ptr.
module mpc_rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt_onehot,
    output logic [W-1:0] gnt_idx,
    output logic         any
);

    int j;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        j          = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && req[W'(j)]) begin
                any                 = 1'b1;
                gnt_idx             = W'(j);
                gnt_onehot[W'(j)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mpc_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among N_REQ requesters.
// Optional issue/stall counters under MPC_MUL_ARB_STATS_EN.
module mpc_mul_arbiter
    import mpc_mul_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 4,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_REQ-1:0]                req_valid,
    output logic [N_REQ-1:0]                req_ready,
    input  logic [N_REQ-1:0][MUL_A_W-1:0]   req_a,
    input  logic [N_REQ-1:0][MUL_B_W-1:0]   req_b,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic signed [MUL_P_W-1:0]       res_p,
`ifdef MPC_MUL_ARB_STATS_EN
    output logic [31:0]                     stat_issue,
    output logic [31:0]                     stat_stall,
`endif
    output logic [ID_W-1:0]                 res_id
);

    logic             adv;
    logic             acc;
    logic             any;
    logic [N_REQ-1:0] gnt_oh;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W-1:0]  ptr;
    mul_a_t           mul_a;
    mul_b_t           mul_b;
    mul_p_t           mul_p;

    logic [LATENCY-1:0] vld;
    logic [ID_W-1:0]    tid [LATENCY];

    mpc_rr_pick #(
        .N (N_REQ),
        .W (ID_W)
    ) u_pick (
        .req        (req_valid),
        .ptr        (ptr),
        .gnt_onehot (gnt_oh),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    // A held result freezes multiplier and tag pipe together.
    assign adv       = !(res_valid && !res_ready);
    assign req_ready = reset ? (gnt_oh & {N_REQ{adv}}) : '0;
    assign acc       = any && adv && reset;
    assign mul_a     = req_a[gnt_idx];
    assign mul_b     = req_b[gnt_idx];

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (acc) begin
            if (gnt_idx == ID_W'(N_REQ-1)) begin
                ptr <= '0;
            end else begin
                ptr <= gnt_idx + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tid[i] <= '0;
            end
        end else if (adv) begin
            vld[0] <= acc;
            tid[0] <= gnt_idx;
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                tid[i] <= tid[i-1];
            end
        end
    end

    assign res_valid = vld[LATENCY-1];
    assign res_id    = tid[LATENCY-1];
    assign res_p     = mul_p;

    mpc_mul_mul_21s_15ns_36_4_1 #(
        .NUM_STAGE (LATENCY)
    ) u_mul (
        .clk  (clk),
        .rst  (!reset),
        .ce   (adv),
        .din0 (mul_a),
        .din1 (mul_b),
        .dout (mul_p)
    );

`ifdef MPC_MUL_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_issue <= '0;
            stat_stall <= '0;
        end else begin
            if (acc && stat_issue != '1) begin
                stat_issue <= stat_issue + 32'd1;
            end
            if (!adv && stat_stall != '1) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule
